// File: rtl/irq_seq_pkg.sv
// Shared definitions for the interrupt sequencer: FSM state encoding and the
// micro-instructions injected into the fetch-to-decode path.
package irq_seq_pkg;

  typedef logic [3:0] state_t;

  // Sequencer states (4-bit encoding, also exported on the debug port).
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PUSH_PCH = 4'd1;
  localparam logic [3:0] S_PUSH_PCL = 4'd2;
  localparam logic [3:0] S_PUSH_CCR = 4'd3;
  localparam logic [3:0] S_VECTOR   = 4'd4;
  localparam logic [3:0] S_SERVICE  = 4'd5;
  localparam logic [3:0] S_POP_CCR  = 4'd6;
  localparam logic [3:0] S_POP_PCL  = 4'd7;
  localparam logic [3:0] S_POP_PCH  = 4'd8;

  // Injected instructions, aligned with the control-unit opcode map.
  localparam logic [15:0] INSTR_NOP      = 16'h0000;
  localparam logic [15:0] INSTR_PUSH_PCH = 16'hE001;
  localparam logic [15:0] INSTR_PUSH_PCL = 16'hE002;
  localparam logic [15:0] INSTR_PUSH_CCR = 16'hE003;
  localparam logic [15:0] INSTR_POP_CCR  = 16'hE803;
  localparam logic [15:0] INSTR_POP_PCL  = 16'hE802;
  localparam logic [15:0] INSTR_POP_PCH  = 16'hE801;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest-index active request wins.
// Produces both a one-hot grant and the binary index of the winner.
module irq_prio_enc #(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_IRQ-1:0] req,
  output logic [N_IRQ-1:0] grant,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  assign valid = |req;

  // Isolate the lowest set bit (two's-complement trick).
  assign grant = req & (~req + N_IRQ'(1));

  // Scan from the top so the lowest active index is written last and wins.
  always_comb begin
    id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Multi-channel interrupt sequencer for the fetch stage. Latches request
// edges, accepts one unmasked channel at a time (lowest index first), injects
// the context-save pushes, redirects PC to the channel vector, and on RTI
// injects the matching restore pops.
//
// Handshake: the injected word (instr_valid) and the acknowledge (ack) act as
// "valid"; !pipe_stall acts as "ready". A word or ack is consumed only on a
// rising edge where pipe_stall is low; while stalled, every output and all
// sequencer state hold, and ack is never raised.
module irq_sequencer
  import irq_seq_pkg::*;
#(
  parameter int          INSTR_W    = 16,
  parameter int          PC_W       = 32,
  parameter int          N_IRQ      = 4,
  parameter int unsigned VEC_BASE   = 0,
  parameter int unsigned VEC_STRIDE = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_IRQ-1:0]   irq_req,
  input  logic [N_IRQ-1:0]   irq_mask,
  input  logic               rti,
  input  logic               pipe_stall,
  input  logic [PC_W-1:0]    pc_in,
  output logic [N_IRQ-1:0]   ack,
  output logic               pc_stop,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] push_data,
  output logic               pc_change,
  output logic [PC_W-1:0]    pc_value,
  output logic               in_service,
  output logic               busy,
  output logic [3:0]         state_dbg,
  output logic [N_IRQ-1:0]   pending_dbg
);

  localparam int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int PCH_W = PC_W - INSTR_W;

  state_t             state;
  logic [N_IRQ-1:0]   irq_prev;
  logic [N_IRQ-1:0]   pending;
  logic [N_IRQ-1:0]   rise;
  logic [N_IRQ-1:0]   eligible;
  logic [N_IRQ-1:0]   grant;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;
  logic               accept;
  logic [PC_W-1:0]    saved_pc;
  logic [ID_W-1:0]    saved_id;
  logic [INSTR_W-1:0] pch_word;
  logic [PC_W-1:0]    vec_addr;

  assign rise     = irq_req & ~irq_prev;
  assign eligible = pending & ~irq_mask;

  irq_prio_enc #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_prio (
    .req   (eligible),
    .grant (grant),
    .id    (win_id),
    .valid (win_valid)
  );

  // Acceptance depends only on registered pending/state plus mask and stall,
  // so there is no combinational path from irq_req to any output.
  assign accept = (state == S_IDLE) && !pipe_stall && !reset && win_valid;
  assign ack    = accept ? grant : '0;

  // Edge capture, pending bookkeeping and the sequencer FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      irq_prev <= '0;
      pending  <= '0;
      saved_pc <= '0;
      saved_id <= '0;
    end else begin
      irq_prev <= irq_req;
      // A new edge on the clearing cycle re-sets the bit (set wins).
      pending  <= (pending & ~ack) | rise;
      if (!pipe_stall) begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              saved_pc <= pc_in;
              saved_id <= win_id;
              state    <= S_PUSH_PCH;
            end
          end
          S_PUSH_PCH: state <= S_PUSH_PCL;
          S_PUSH_PCL: state <= S_PUSH_CCR;
          S_PUSH_CCR: state <= S_VECTOR;
          S_VECTOR:   state <= S_SERVICE;
          S_SERVICE:  if (rti) state <= S_POP_CCR;
          S_POP_CCR:  state <= S_POP_PCL;
          S_POP_PCL:  state <= S_POP_PCH;
          S_POP_PCH:  state <= S_IDLE;
          default:    state <= S_IDLE;
        endcase
      end
    end
  end

  // Upper PC half, zero-extended to a full instruction word.
  always_comb begin
    pch_word = '0;
    pch_word[PCH_W-1:0] = saved_pc[PC_W-1:INSTR_W];
  end

  // Vector address computed at PC width; wraps naturally modulo 2^PC_W.
  assign vec_addr = PC_W'(VEC_BASE) + PC_W'(saved_id) * PC_W'(VEC_STRIDE);

  // Output decode from the registered state.
  always_comb begin
    pc_stop     = 1'b0;
    instr_valid = 1'b0;
    instr_out   = '0;
    push_data   = '0;
    pc_change   = 1'b0;
    pc_value    = '0;
    in_service  = 1'b0;
    case (state)
      S_PUSH_PCH: begin
        pc_stop     = 1'b1;
        instr_valid = 1'b1;
        instr_out   = INSTR_W'(INSTR_PUSH_PCH);
        push_data   = pch_word;
      end
      S_PUSH_PCL: begin
        pc_stop     = 1'b1;
        instr_valid = 1'b1;
        instr_out   = INSTR_W'(INSTR_PUSH_PCL);
        push_data   = saved_pc[INSTR_W-1:0];
      end
      S_PUSH_CCR: begin
        pc_stop     = 1'b1;
        instr_valid = 1'b1;
        instr_out   = INSTR_W'(INSTR_PUSH_CCR);
      end
      S_VECTOR: begin
        instr_valid = 1'b1;
        instr_out   = INSTR_W'(INSTR_NOP);
        pc_change   = 1'b1;
        pc_value    = vec_addr;
      end
      S_SERVICE: begin
        in_service = 1'b1;
      end
      S_POP_CCR: begin
        pc_stop     = 1'b1;
        instr_valid = 1'b1;
        instr_out   = INSTR_W'(INSTR_POP_CCR);
      end
      S_POP_PCL: begin
        pc_stop     = 1'b1;
        instr_valid = 1'b1;
        instr_out   = INSTR_W'(INSTR_POP_PCL);
      end
      S_POP_PCH: begin
        pc_stop     = 1'b1;
        instr_valid = 1'b1;
        instr_out   = INSTR_W'(INSTR_POP_PCH);
      end
      default: ;
    endcase
  end

  assign busy        = (state != S_IDLE) && (state != S_SERVICE);
  assign state_dbg   = state;
  assign pending_dbg = pending;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed scoreboard bench for irq_sequencer. Stimulus pushes the expected
// ack/injected-word stream into exp_q; a negedge monitor pops and compares
// every word the DUT hands over (valid = ack or instr_valid, ready = !stall).
module tb_irq_sequencer;
  import irq_seq_pkg::*;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 32;
  localparam int N_IRQ   = 4;
  localparam int EV_W    = N_IRQ + INSTR_W + INSTR_W + 1 + PC_W;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N_IRQ-1:0]   irq_req = '0;
  logic [N_IRQ-1:0]   irq_mask = '0;
  logic               rti = 1'b0;
  logic               pipe_stall = 1'b0;
  logic [PC_W-1:0]    pc_in = '0;
  logic [N_IRQ-1:0]   ack;
  logic               pc_stop;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [INSTR_W-1:0] push_data;
  logic               pc_change;
  logic [PC_W-1:0]    pc_value;
  logic               in_service;
  logic               busy;
  logic [3:0]         state_dbg;
  logic [N_IRQ-1:0]   pending_dbg;

  int errors = 0;
  int checks = 0;
  logic [EV_W-1:0] exp_q[$];
  logic [EV_W-1:0] obs;
  logic [EV_W-1:0] exp_ev;

  irq_sequencer #(
    .INSTR_W    (INSTR_W),
    .PC_W       (PC_W),
    .N_IRQ      (N_IRQ),
    .VEC_BASE   (32'h100),
    .VEC_STRIDE (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_req     (irq_req),
    .irq_mask    (irq_mask),
    .rti         (rti),
    .pipe_stall  (pipe_stall),
    .pc_in       (pc_in),
    .ack         (ack),
    .pc_stop     (pc_stop),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .push_data   (push_data),
    .pc_change   (pc_change),
    .pc_value    (pc_value),
    .in_service  (in_service),
    .busy        (busy),
    .state_dbg   (state_dbg),
    .pending_dbg (pending_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Scoreboard monitor: one pop per handed-over word
  always @(negedge clk) begin
    if (!reset && !pipe_stall && ((ack != '0) || instr_valid)) begin
      obs = {ack, instr_out, push_data, pc_change, pc_value};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h expected none", obs);
      end else begin
        exp_ev = exp_q.pop_front();
        if (obs !== exp_ev) begin
          errors++;
          $display("FAIL scoreboard: got %h expected %h", obs, exp_ev);
        end
      end
    end
  end

  function automatic logic [EV_W-1:0] ev(input logic [N_IRQ-1:0] a, input logic [15:0] i,
                                         input logic [15:0] d, input logic c, input logic [31:0] v);
    return {a, i, d, c, v};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string name);
    int n = 0;
    while (state_dbg !== s && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(state_dbg), 64'(s));
  endtask

  task automatic push_entry(input logic [N_IRQ-1:0] a, input logic [15:0] hi,
                            input logic [15:0] lo, input logic [31:0] vec);
    exp_q.push_back(ev(a, 16'h0, 16'h0, 1'b0, 32'h0));
    exp_q.push_back(ev('0, INSTR_PUSH_PCH, hi, 1'b0, 32'h0));
    exp_q.push_back(ev('0, INSTR_PUSH_PCL, lo, 1'b0, 32'h0));
    exp_q.push_back(ev('0, INSTR_PUSH_CCR, 16'h0, 1'b0, 32'h0));
    exp_q.push_back(ev('0, INSTR_NOP, 16'h0, 1'b1, vec));
  endtask

  task automatic push_restore();
    exp_q.push_back(ev('0, INSTR_POP_CCR, 16'h0, 1'b0, 32'h0));
    exp_q.push_back(ev('0, INSTR_POP_PCL, 16'h0, 1'b0, 32'h0));
    exp_q.push_back(ev('0, INSTR_POP_PCH, 16'h0, 1'b0, 32'h0));
  endtask

  task automatic do_rti();
    rti = 1'b1;
    tick();
    rti = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({ack, pc_stop, instr_valid, pc_change, in_service, busy}), 64'h0);
    check({name, "_words"}, 64'({instr_out, push_data}), 64'h0);
    check({name, "_pcv"}, 64'(pc_value), 64'h0);
    check({name, "_state"}, 64'(state_dbg), 64'(S_IDLE));
    check({name, "_pending"}, 64'(pending_dbg), 64'h0);
  endtask

  // Directed sequence and final report
  initial begin
    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("reset");

    // 1: single edge on channel 2, PC 0x00012345 -> vector 0x104
    pc_in = 32'h0001_2345;
    push_entry(4'b0100, 16'h0001, 16'h2345, 32'h104);
    irq_req = 4'b0100;
    tick();
    check("t1_ack_latency", 64'(ack), 64'h4);
    repeat (4) tick();
    check("t1_pc_change_t5", 64'(pc_change), 64'h1);
    check("t1_pc_stop_vec", 64'(pc_stop), 64'h0);
    tick();
    check("t1_in_service", 64'({in_service, busy}), 64'h2);
    irq_req = '0;
    push_restore();
    do_rti();
    wait_state(S_IDLE, 10, "t1_back_idle");

    // 2: channels 1 and 3 together; 1 first, 3 on the first IDLE cycle
    pc_in = 32'hABCD_0010;
    push_entry(4'b0010, 16'hABCD, 16'h0010, 32'h102);
    irq_req = 4'b1010;
    wait_state(S_SERVICE, 10, "t2_service1");
    check("t2_pending3", 64'(pending_dbg), 64'h8);
    push_restore();
    push_entry(4'b1000, 16'hABCD, 16'h0010, 32'h106);
    do_rti();
    wait_state(S_POP_PCH, 5, "t2_pop_pch");
    tick();
    check("t2_ack3_first_idle", 64'(ack), 64'h8);
    wait_state(S_SERVICE, 10, "t2_service3");
    irq_req = '0;
    push_restore();
    do_rti();
    wait_state(S_IDLE, 10, "t2_back_idle");

    // 3: masked channel 0 stays pending, acked once unmasked
    irq_mask = 4'b0001;
    irq_req  = 4'b0001;
    repeat (20) tick();
    check("t3_masked_pending", 64'(pending_dbg), 64'h1);
    check("t3_masked_idle", 64'(state_dbg), 64'(S_IDLE));
    push_entry(4'b0001, 16'hABCD, 16'h0010, 32'h100);
    irq_mask = '0;
    #1;
    check("t3_ack_unmask", 64'(ack), 64'h1);
    wait_state(S_SERVICE, 10, "t3_service");
    irq_req = '0;
    push_restore();
    do_rti();
    wait_state(S_IDLE, 10, "t3_back_idle");

    // 4: three-cycle stall while in PUSH_PCL
    pc_in = 32'h0002_BEEF;
    push_entry(4'b0100, 16'h0002, 16'hBEEF, 32'h104);
    irq_req = 4'b0100;
    wait_state(S_PUSH_PCL, 10, "t4_reach_pcl");
    pipe_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_stall_instr", 64'(instr_out), 64'(INSTR_PUSH_PCL));
      check("t4_stall_data", 64'(push_data), 64'hBEEF);
      check("t4_stall_ack", 64'(ack), 64'h0);
    end
    pipe_stall = 1'b0;
    irq_req = '0;
    wait_state(S_SERVICE, 10, "t4_service");
    push_restore();
    do_rti();
    wait_state(S_IDLE, 10, "t4_back_idle");

    // 5: reset while in VECTOR
    exp_q.push_back(ev(4'b0010, 16'h0, 16'h0, 1'b0, 32'h0));
    exp_q.push_back(ev('0, INSTR_PUSH_PCH, 16'h0002, 1'b0, 32'h0));
    exp_q.push_back(ev('0, INSTR_PUSH_PCL, 16'hBEEF, 1'b0, 32'h0));
    exp_q.push_back(ev('0, INSTR_PUSH_CCR, 16'h0, 1'b0, 32'h0));
    irq_req = 4'b0010;
    wait_state(S_VECTOR, 10, "t5_reach_vector");
    reset = 1'b1;
    irq_req = '0;
    tick();
    reset = 1'b0;
    check_all_zero("t5_reset");
    check("t5_queue_drained", 64'(exp_q.size()), 64'h0);
    repeat (3) tick();
    check("t5_stays_idle", 64'({state_dbg, instr_valid}), 64'h0);

    // 6: RTI while IDLE, then an edge arriving during POP_PCL
    do_rti();
    repeat (3) tick();
    check("t6_rti_idle", 64'({state_dbg, instr_valid}), 64'h0);
    pc_in = 32'h0001_2345;
    push_entry(4'b0010, 16'h0001, 16'h2345, 32'h102);
    irq_req = 4'b0010;
    wait_state(S_SERVICE, 10, "t6_service1");
    push_restore();
    push_entry(4'b0001, 16'h0001, 16'h2345, 32'h100);
    do_rti();
    wait_state(S_POP_PCL, 5, "t6_pop_pcl");
    irq_req = 4'b0011;
    tick();
    check("t6_held_pending", 64'({pending_dbg, ack}), 64'h10);
    tick();
    check("t6_ack0_after_pop", 64'(ack), 64'h1);
    wait_state(S_SERVICE, 10, "t6_service0");
    irq_req = '0;
    push_restore();
    do_rti();
    wait_state(S_IDLE, 10, "t6_back_idle");

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        tick();
        n++;
      end
    end
    check("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Parametrised, multi-channel successor to the single-line interrupt sequencer in the five-stage pipeline.
- Latches N_IRQ interrupt requests, supports masking and fixed priority, and acknowledges one channel at a time.
- Injects the context-save micro-instructions into the fetch-to-decode path, then redirects PC to a per-channel vector.
- On RTI, injects the matching restore sequence. Sits in the fetch stage beside the instruction-injection muxes.

Parameters:
- INSTR_W, 16, instruction and push-data width.
- PC_W, 32, program-counter width; must satisfy INSTR_W < PC_W <= 2*INSTR_W.
- N_IRQ, 4, number of interrupt channels (1..8).
- VEC_BASE, 0, vector address of channel 0.
- VEC_STRIDE, 2, address distance between consecutive channel vectors.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_req  in  N_IRQ  level requests; a rising edge per bit sets pending.
- irq_mask  in  N_IRQ  1 = channel blocked from acceptance; pending is kept.
- rti  in  1  decode-stage RTI pulse.
- pipe_stall  in  1  load-use stall; freezes the sequencer.
- pc_in  in  PC_W  current fetch PC.
- ack  out  N_IRQ  one-hot, one-cycle acknowledge.
- pc_stop  out  1  inhibits PC increment.
- instr_valid  out  1  selects instr_out over the fetched instruction.
- instr_out  out  INSTR_W  injected instruction.
- push_data  out  INSTR_W  data word for the current push.
- pc_change  out  1  load pc_value into PC.
- pc_value  out  PC_W  vector address.
- in_service  out  1  a handler is active.
- busy  out  1  state is not IDLE and not SERVICE.

Behaviour:
- Reset: state=IDLE; pending, edge-detect and saved registers clear; every output is 0.
- Pending:
  - pending[i] sets on a 0->1 edge of irq_req[i].
  - pending[i] clears on the edge its ack fires.
  - If a new edge arrives on the clearing edge, set wins.
- Acceptance:
  - Condition: state==IDLE, !pipe_stall, and (pending & ~irq_mask) != 0.
  - Winner is the lowest index.
  - ack[id] is high in the acceptance cycle.
  - saved_pc <= pc_in, saved_id <= id, next state PUSH_PCH.
  - Accepted cycle is registered; no combinational path from irq_req to outputs.
- Save sequence: PUSH_PCH -> PUSH_PCL -> PUSH_CCR -> VECTOR -> SERVICE.
  - Each state emits one word for one cycle: instr_valid=1, pc_stop=1.
  - instr_out = INSTR_PUSH_PCH / INSTR_PUSH_PCL / INSTR_PUSH_CCR respectively.
  - push_data = saved_pc[PC_W-1:INSTR_W] zero-extended for PUSH_PCH.
  - push_data = saved_pc[INSTR_W-1:0] for PUSH_PCL.
  - push_data = 0 for PUSH_CCR.
- VECTOR:
  - instr_valid=1, instr_out=INSTR_NOP, pc_change=1.
  - pc_value = VEC_BASE + saved_id*VEC_STRIDE, computed at PC_W width; wraps modulo 2^PC_W.
  - pc_stop=0.
- SERVICE:
  - in_service=1; no new acceptance (no nesting); requests keep pending.
  - rti=1 moves to POP_CCR; rti in any other state is ignored.
- Restore sequence: POP_CCR -> POP_PCL -> POP_PCH -> IDLE.
  - Emits INSTR_POP_CCR / INSTR_POP_PCL / INSTR_POP_PCH with instr_valid=1, pc_stop=1.
  - PC reload is performed downstream.
  - Acceptance is possible on the first IDLE cycle after POP_PCH.
- pipe_stall=1: state, outputs and saved registers hold. ack is never issued during a stall; pending edges are still captured.
- Latency:
  - Request edge at cycle t: pending visible t+1, ack t+1 if IDLE.
  - First push at t+2; pc_change at t+5.
- Reset mid-sequence: immediate return to IDLE; no further injection.
- Masked channels: an ack is never issued; pending persists until unmasked and accepted.

Decomposition:
- Package irq_seq_pkg holds:
  - state encoding (IDLE, PUSH_PCH, PUSH_PCL, PUSH_CCR, VECTOR, SERVICE, POP_CCR, POP_PCL, POP_PCH);
  - injected instruction constants INSTR_NOP, INSTR_PUSH_PCH, INSTR_PUSH_PCL, INSTR_PUSH_CCR, INSTR_POP_CCR, INSTR_POP_PCL, INSTR_POP_PCH, matching the control-unit opcode map.
- One sub-module, irq_prio_enc: parametrised N_IRQ priority encoder producing id and a valid flag.

Test Plan:
- Single irq_req[2] edge, VEC_BASE=0x100, pc_in=0x00012345:
  - ack=4'b0100 one cycle; push_data 0x0001 then 0x2345 then 0x0000;
  - pc_change with pc_value=0x104; in_service=1.
- irq_req=4'b1010 rising together:
  - ack[1] first; after rti and the 3 pops, ack[3] on the next IDLE cycle.
- irq_mask[0]=1, irq_req[0] edge: no ack for 20 cycles; clear the mask -> ack[0] the next cycle.
- pipe_stall=1 for 3 cycles during PUSH_PCL: instr_out stays INSTR_PUSH_PCL, push_data is constant, and the sequence then resumes.
- reset=1 in VECTOR: next cycle all outputs 0, state IDLE, pending=0.
- rti pulse while IDLE: no injection. irq edge during POP_PCL: held pending and acked after POP_PCH.
